// File: rtl/ima_adpcm_pkg.sv
// IMA ADPCM shared types, tables and helpers.
// Used by both the encoder and the decoder.
package ima_adpcm_pkg;

  typedef logic signed [15:0] sample_t;
  typedef logic [3:0]         nibble_t;
  typedef logic [6:0]         index_t;
  typedef logic [14:0]        step_t;

  localparam int IMA_MAX_INDEX = 88;

  localparam step_t IMA_STEP_TABLE [89] = '{
    15'd7,     15'd8,     15'd9,     15'd10,
    15'd11,    15'd12,    15'd13,    15'd14,
    15'd16,    15'd17,    15'd19,    15'd21,
    15'd23,    15'd25,    15'd28,    15'd31,
    15'd34,    15'd37,    15'd41,    15'd45,
    15'd50,    15'd55,    15'd60,    15'd66,
    15'd73,    15'd80,    15'd88,    15'd97,
    15'd107,   15'd118,   15'd130,   15'd143,
    15'd157,   15'd173,   15'd190,   15'd209,
    15'd230,   15'd253,   15'd279,   15'd307,
    15'd337,   15'd371,   15'd408,   15'd449,
    15'd494,   15'd544,   15'd598,   15'd658,
    15'd724,   15'd796,   15'd876,   15'd963,
    15'd1060,  15'd1166,  15'd1282,  15'd1411,
    15'd1552,  15'd1707,  15'd1878,  15'd2066,
    15'd2272,  15'd2499,  15'd2749,  15'd3024,
    15'd3327,  15'd3660,  15'd4026,  15'd4428,
    15'd4871,  15'd5358,  15'd5894,  15'd6484,
    15'd7132,  15'd7845,  15'd8630,  15'd9493,
    15'd10442, 15'd11487, 15'd12635, 15'd13899,
    15'd15289, 15'd16818, 15'd18500, 15'd20350,
    15'd22385, 15'd24623, 15'd27086, 15'd29794,
    15'd32767
  };

  // Indexed by magnitude only; the sign bit
  // does not affect the index adjustment.
  localparam logic signed [4:0] IMA_INDEX_TABLE [8] = '{
    -5'sd1, -5'sd1, -5'sd1, -5'sd1,
    5'sd2,  5'sd4,  5'sd6,  5'sd8
  };

  function automatic sample_t sat16(
    input logic signed [16:0] v
  );
    if (v > 17'sd32767)
      return 16'sh7FFF;
    else if (v < -17'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

endpackage

// File: rtl/ima_adpcm_if.sv
// Packet-framed PCM in / ADPCM nibble out bundle.
// master drives samples, slave is the encoder.
interface ima_adpcm_if;
  import ima_adpcm_pkg::*;

  logic    sop;
  logic    eop;
  sample_t sample_i;
  logic    valid_o;
  logic    sop_o;
  logic    eop_o;
  nibble_t coded_o;
  sample_t recon_o;

  modport master (
    output sop, eop, sample_i,
    input  valid_o, sop_o, eop_o,
    input  coded_o, recon_o
  );

  modport slave (
    input  sop, eop, sample_i,
    output valid_o, sop_o, eop_o,
    output coded_o, recon_o
  );

endinterface

// File: rtl/ima_adpcm_step_ctrl.sv
// Index adaptation with clamp and step lookup.
// Purely combinational, shared with the decoder.
module ima_adpcm_step_ctrl
  import ima_adpcm_pkg::*;
(
  input  index_t     idx,
  input  logic [2:0] mag,
  output index_t     idx_next,
  output step_t      step_next
);

  logic signed [4:0] adj;
  logic signed [7:0] sum;

  always_comb begin
    adj = IMA_INDEX_TABLE[mag];
    sum = $signed({1'b0, idx})
        + $signed({{3{adj[4]}}, adj});
    if (sum[7])
      idx_next = '0;
    else if (sum > 8'sd88)
      idx_next = index_t'(IMA_MAX_INDEX);
    else
      idx_next = sum[6:0];
    step_next = IMA_STEP_TABLE[idx_next];
  end

endmodule

// File: rtl/ima_adpcm_encoder.sv
// Streaming IMA ADPCM encoder, one sample/clock,
// two-register latency with sop/eop alignment.
module ima_adpcm_encoder
  import ima_adpcm_pkg::*;
(
  input logic        clk,
  input logic        rst,
  ima_adpcm_if.slave bus
);

  logic    in_pkt;
  logic    accept;
  logic    s1_vld;
  logic    s1_sop;
  logic    s1_eop;
  sample_t s1_smp;

  sample_t pred_q;
  index_t  idx_q;
  step_t   step_q;
  logic    valid_q;
  logic    sop_q;
  logic    eop_q;
  nibble_t coded_q;

  sample_t           pred_cur;
  index_t            idx_cur;
  step_t             step_cur;
  logic signed [16:0] diff;
  logic              sgn;
  logic [16:0]       mag_a;
  logic [16:0]       r1;
  logic [16:0]       r2;
  logic [2:0]        mag;
  logic [18:0]       prod;
  logic [15:0]       vpdiff;
  logic signed [16:0] pred_sum;
  sample_t           pred_next;
  index_t            idx_next;
  step_t             step_next;

  assign accept = bus.sop | in_pkt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_pkt <= 1'b0;
      s1_vld <= 1'b0;
      s1_sop <= 1'b0;
      s1_eop <= 1'b0;
      s1_smp <= '0;
    end else begin
      in_pkt <= accept & ~bus.eop;
      s1_vld <= accept;
      s1_sop <= bus.sop;
      s1_eop <= bus.eop & accept;
      s1_smp <= bus.sample_i;
    end
  end

  // Quantize and reconstruct in one cycle: this
  // loop closes through pred_q every sample.
  always_comb begin
    pred_cur = s1_sop ? '0 : pred_q;
    idx_cur  = s1_sop ? '0 : idx_q;
    step_cur = s1_sop ? IMA_STEP_TABLE[0]
                      : step_q;
    diff = $signed({s1_smp[15], s1_smp})
         - $signed({pred_cur[15], pred_cur});
    sgn   = diff[16];
    mag_a = sgn ? 17'(-diff) : 17'(diff);

    mag[2] = mag_a >= {2'b0, step_cur};
    r1 = mag[2] ? mag_a - {2'b0, step_cur}
                : mag_a;
    mag[1] = r1 >= {3'b0, step_cur[14:1]};
    r2 = mag[1] ? r1 - {3'b0, step_cur[14:1]}
                : r1;
    mag[0] = r2 >= {4'b0, step_cur[14:2]};

    prod   = {15'b0, mag, 1'b1}
           * {4'b0, step_cur};
    vpdiff = 16'(prod >> 3);
    pred_sum = sgn
      ? $signed({pred_cur[15], pred_cur})
        - $signed({1'b0, vpdiff})
      : $signed({pred_cur[15], pred_cur})
        + $signed({1'b0, vpdiff});
    pred_next = sat16(pred_sum);
  end

  ima_adpcm_step_ctrl u_step (
    .idx       (idx_cur),
    .mag       (mag),
    .idx_next  (idx_next),
    .step_next (step_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      coded_q <= '0;
      pred_q  <= '0;
      idx_q   <= '0;
      step_q  <= IMA_STEP_TABLE[0];
    end else begin
      valid_q <= s1_vld;
      sop_q   <= s1_vld & s1_sop;
      eop_q   <= s1_vld & s1_eop;
      if (s1_vld) begin
        coded_q <= {sgn, mag};
        pred_q  <= pred_next;
        idx_q   <= idx_next;
        step_q  <= step_next;
      end
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.sop_o   = sop_q;
  assign bus.eop_o   = eop_q;
  assign bus.coded_o = coded_q;
  assign bus.recon_o = pred_q;

endmodule

// File: tb/tb_ima_adpcm_encoder.sv
// Directed bench for ima_adpcm_encoder with a
// reference decoder for the loopback scenario.
module tb_ima_adpcm_encoder;
  import ima_adpcm_pkg::*;

  typedef struct packed {
    logic        s;
    logic        e;
    logic [15:0] x;
  } in_t;

  typedef struct packed {
    logic        v;
    logic        so;
    logic        eo;
    logic [3:0]  c;
    logic [15:0] r;
  } out_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ima_adpcm_if bus ();

  ima_adpcm_encoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cycle(
    input logic s, input logic e,
    input logic [15:0] x
  );
    bus.sop      = s;
    bus.eop      = e;
    bus.sample_i = x;
    @(posedge clk);
    #1;
  endtask

  function automatic out_t outs();
    return {bus.valid_o, bus.sop_o, bus.eop_o,
            bus.coded_o, bus.recon_o};
  endfunction

  task automatic test_reset();
    out_t g;
    rst = 1'b1;
    bus.sop = 1'b0;
    bus.eop = 1'b0;
    bus.sample_i = '0;
    repeat (2) @(posedge clk);
    #1;
    g = outs();
    checks++;
    if (g !== '0) begin
      errors++;
      $display("FAIL reset: got v=%b sop=%b eop=%b coded=%h recon=%h, want all 0",
               g.v, g.so, g.eo, g.c, g.r);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    in_t  st [5];
    out_t ex [5];
    out_t g;
    st[0] = {2'b10, 16'd0};    ex[0] = {3'b000, 4'h0, 16'd0};
    st[1] = {2'b00, 16'd1000}; ex[1] = {3'b110, 4'h0, 16'd0};
    st[2] = {2'b01, 16'd1000}; ex[2] = {3'b100, 4'h7, 16'd13};
    st[3] = {2'b00, 16'd0};    ex[3] = {3'b101, 4'h7, 16'd43};
    st[4] = {2'b00, 16'd0};    ex[4] = {3'b000, 4'h7, 16'd43};
    for (int k = 0; k < 5; k++) begin
      cycle(st[k].s, st[k].e, st[k].x);
      g = outs();
      checks++;
      if (g !== ex[k]) begin
        errors++;
        $display("FAIL basic[%0d]: got v=%b sop=%b eop=%b coded=%h recon=%h, want v=%b sop=%b eop=%b coded=%h recon=%h",
                 k, g.v, g.so, g.eo, g.c, g.r,
                 ex[k].v, ex[k].so, ex[k].eo, ex[k].c, ex[k].r);
      end
    end
  endtask

  task automatic test_negative();
    in_t  st [3];
    out_t ex [3];
    out_t g;
    st[0] = {2'b11, 16'hFF9C}; ex[0] = {3'b000, 4'h7, 16'd43};
    st[1] = {2'b00, 16'd0};    ex[1] = {3'b111, 4'hF, 16'hFFF3};
    st[2] = {2'b00, 16'd0};    ex[2] = {3'b000, 4'hF, 16'hFFF3};
    for (int k = 0; k < 3; k++) begin
      cycle(st[k].s, st[k].e, st[k].x);
      g = outs();
      checks++;
      if (g !== ex[k]) begin
        errors++;
        $display("FAIL negative[%0d]: got v=%b sop=%b eop=%b coded=%h recon=%h, want v=%b sop=%b eop=%b coded=%h recon=%h",
                 k, g.v, g.so, g.eo, g.c, g.r,
                 ex[k].v, ex[k].so, ex[k].eo, ex[k].c, ex[k].r);
      end
    end
  endtask

  // Small deltas: index clamps at 0, sign flips.
  task automatic test_small();
    in_t  st [5];
    out_t ex [5];
    out_t g;
    st[0] = {2'b10, 16'd2}; ex[0] = {3'b000, 4'hF, 16'hFFF3};
    st[1] = {2'b00, 16'd2}; ex[1] = {3'b110, 4'h1, 16'd2};
    st[2] = {2'b01, 16'd0}; ex[2] = {3'b100, 4'h0, 16'd2};
    st[3] = {2'b00, 16'd0}; ex[3] = {3'b101, 4'h9, 16'd0};
    st[4] = {2'b00, 16'd0}; ex[4] = {3'b000, 4'h9, 16'd0};
    for (int k = 0; k < 5; k++) begin
      cycle(st[k].s, st[k].e, st[k].x);
      g = outs();
      checks++;
      if (g !== ex[k]) begin
        errors++;
        $display("FAIL small[%0d]: got v=%b sop=%b eop=%b coded=%h recon=%h, want v=%b sop=%b eop=%b coded=%h recon=%h",
                 k, g.v, g.so, g.eo, g.c, g.r,
                 ex[k].v, ex[k].so, ex[k].eo, ex[k].c, ex[k].r);
      end
    end
  endtask

  task automatic test_back_to_back();
    in_t  st [5];
    out_t ex [5];
    out_t g;
    st[0] = {2'b11, 16'hFF9C}; ex[0] = {3'b000, 4'h9, 16'd0};
    st[1] = {2'b11, 16'd1000}; ex[1] = {3'b111, 4'hF, 16'hFFF3};
    st[2] = {2'b11, 16'd0};    ex[2] = {3'b111, 4'h7, 16'd13};
    st[3] = {2'b00, 16'd0};    ex[3] = {3'b111, 4'h0, 16'd0};
    st[4] = {2'b00, 16'd0};    ex[4] = {3'b000, 4'h0, 16'd0};
    for (int k = 0; k < 5; k++) begin
      cycle(st[k].s, st[k].e, st[k].x);
      g = outs();
      checks++;
      if (g !== ex[k]) begin
        errors++;
        $display("FAIL b2b[%0d]: got v=%b sop=%b eop=%b coded=%h recon=%h, want v=%b sop=%b eop=%b coded=%h recon=%h",
                 k, g.v, g.so, g.eo, g.c, g.r,
                 ex[k].v, ex[k].so, ex[k].eo, ex[k].c, ex[k].r);
      end
    end
  endtask

  task automatic test_saturation();
    int   sat_r [11];
    logic [3:0] sat_c [11];
    int   vcnt;
    int   prev;
    bit   top;
    sat_r = '{13, 43, 106, 242, 536, 1167,
              2524, 5434, 11672, 25044, 32767};
    sat_c = '{4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7,
              4'h7, 4'h7, 4'h7, 4'h7, 4'h2};
    vcnt = 0;
    prev = 0;
    top  = 1'b0;
    for (int k = 0; k < 202; k++) begin
      if (k < 200)
        cycle(k == 0, k == 199, 16'h7FFF);
      else
        cycle(1'b0, 1'b0, 16'h0000);
      if (bus.valid_o) begin
        checks++;
        if (int'($signed(bus.recon_o)) < prev
            || bus.recon_o[15]) begin
          errors++;
          $display("FAIL sat_mono[%0d]: got recon=%h, want >= %0d and non-negative",
                   vcnt, bus.recon_o, prev);
        end
        checks++;
        if (vcnt < 11) begin
          if (bus.recon_o !== 16'(sat_r[vcnt])
              || bus.coded_o !== sat_c[vcnt]) begin
            errors++;
            $display("FAIL sat_ramp[%0d]: got coded=%h recon=%h, want coded=%h recon=%h",
                     vcnt, bus.coded_o, bus.recon_o,
                     sat_c[vcnt], 16'(sat_r[vcnt]));
          end
        end else if (bus.recon_o !== 16'h7FFF
                     || bus.coded_o[2:0] !== 3'd0) begin
          errors++;
          $display("FAIL sat_hold[%0d]: got coded=%h recon=%h, want mag 0 recon=7fff",
                   vcnt, bus.coded_o, bus.recon_o);
        end
        if (bus.recon_o == 16'h7FFF)
          top = 1'b1;
        prev = int'($signed(bus.recon_o));
        vcnt++;
      end
    end
    checks++;
    if (vcnt != 200 || !top) begin
      errors++;
      $display("FAIL sat_count: got valid=%0d top=%b, want valid=200 top=1",
               vcnt, top);
    end
  endtask

  task automatic test_restart();
    in_t  st [12];
    out_t ex [12];
    out_t g;
    st[0]  = {2'b00, 16'd1234}; ex[0]  = {3'b000, 4'h0, 16'h7FFF};
    st[1]  = {2'b00, 16'd1234}; ex[1]  = {3'b000, 4'h0, 16'h7FFF};
    st[2]  = {2'b01, 16'd1234}; ex[2]  = {3'b000, 4'h0, 16'h7FFF};
    st[3]  = {2'b10, 16'd0};    ex[3]  = {3'b000, 4'h0, 16'h7FFF};
    st[4]  = {2'b00, 16'd1000}; ex[4]  = {3'b110, 4'h0, 16'd0};
    st[5]  = {2'b00, 16'd1000}; ex[5]  = {3'b100, 4'h7, 16'd13};
    st[6]  = {2'b10, 16'd0};    ex[6]  = {3'b100, 4'h7, 16'd43};
    st[7]  = {2'b00, 16'd1000}; ex[7]  = {3'b110, 4'h0, 16'd0};
    st[8]  = {2'b01, 16'd1000}; ex[8]  = {3'b100, 4'h7, 16'd13};
    st[9]  = {2'b00, 16'd1234}; ex[9]  = {3'b101, 4'h7, 16'd43};
    st[10] = {2'b00, 16'd1234}; ex[10] = {3'b000, 4'h7, 16'd43};
    st[11] = {2'b00, 16'd0};    ex[11] = {3'b000, 4'h7, 16'd43};
    for (int k = 0; k < 12; k++) begin
      cycle(st[k].s, st[k].e, st[k].x);
      g = outs();
      checks++;
      if (g !== ex[k]) begin
        errors++;
        $display("FAIL restart[%0d]: got v=%b sop=%b eop=%b coded=%h recon=%h, want v=%b sop=%b eop=%b coded=%h recon=%h",
                 k, g.v, g.so, g.eo, g.c, g.r,
                 ex[k].v, ex[k].so, ex[k].eo, ex[k].c, ex[k].r);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_t g;
    cycle(1'b1, 1'b0, 16'd500);
    cycle(1'b0, 1'b0, 16'd500);
    g = outs();
    checks++;
    if (g !== {3'b110, 4'h7, 16'd13}) begin
      errors++;
      $display("FAIL rstmid_pre: got v=%b coded=%h recon=%h, want v=1 coded=7 recon=000d",
               g.v, g.c, g.r);
    end
    bus.sample_i = 16'd600;
    #2;
    rst = 1'b1;
    #1;
    g = outs();
    checks++;
    if (g !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got v=%b sop=%b eop=%b coded=%h recon=%h, want all 0",
               g.v, g.so, g.eo, g.c, g.r);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, k == 1, 16'd700);
      g = outs();
      checks++;
      if (g !== '0) begin
        errors++;
        $display("FAIL rstmid_ignore[%0d]: got v=%b coded=%h recon=%h, want v=0 coded=0 recon=0",
                 k, g.v, g.c, g.r);
      end
    end
    cycle(1'b1, 1'b1, 16'd1000);
    cycle(1'b0, 1'b0, 16'd0);
    g = outs();
    checks++;
    if (g !== {3'b111, 4'h7, 16'd13}) begin
      errors++;
      $display("FAIL rstmid_resume: got v=%b sop=%b eop=%b coded=%h recon=%h, want v=1 sop=1 eop=1 coded=7 recon=000d",
               g.v, g.so, g.eo, g.c, g.r);
    end
  endtask

  task automatic test_loopback();
    int mp;
    int mi;
    int vp;
    int m;
    int w;
    int vcnt;
    logic [15:0] smp;
    mp   = 0;
    mi   = 0;
    w    = 0;
    vcnt = 0;
    for (int k = 0; k < 1002; k++) begin
      if (k < 500) begin
        smp = 16'($urandom);
      end else begin
        w = w + int'($urandom_range(0, 2000)) - 1000;
        if (w > 32767) w = 32767;
        if (w < -32768) w = -32768;
        smp = 16'(w);
      end
      if (k < 1000)
        cycle(k == 0, k == 999, smp);
      else
        cycle(1'b0, 1'b0, 16'd0);
      if (bus.valid_o) begin
        if (bus.sop_o) begin
          mp = 0;
          mi = 0;
        end
        m  = int'(bus.coded_o[2:0]);
        vp = ((2 * m + 1) * int'(IMA_STEP_TABLE[mi])) >>> 3;
        mp = bus.coded_o[3] ? mp - vp : mp + vp;
        if (mp > 32767) mp = 32767;
        if (mp < -32768) mp = -32768;
        mi = mi + int'(IMA_INDEX_TABLE[m]);
        if (mi < 0) mi = 0;
        if (mi > 88) mi = 88;
        checks++;
        if (bus.recon_o !== 16'(mp)) begin
          errors++;
          $display("FAIL loopback[%0d]: got recon=%h, want decoded=%h",
                   vcnt, bus.recon_o, 16'(mp));
        end
        vcnt++;
      end
    end
    checks++;
    if (vcnt != 1000) begin
      errors++;
      $display("FAIL loopback_count: got %0d nibbles, want 1000",
               vcnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_small();
    test_back_to_back();
    test_saturation();
    test_restart();
    test_reset_mid();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
